// File: rtl/address_range_generator.sv
// ============================================================================
// Module   : address_range_generator
// Brief    : Walks base..bound (inclusive) in steps of stride and presents
//            each address on a valid/ready handshake. Optional wrap mode
//            restarts at base forever; stop aborts a walk at any time.
// Options  : ADDRESS_RANGE_GENERATOR_COUNT_EN adds xfer_count_o, the number
//            of transfers completed in the current walk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module address_range_generator #(
    parameter int ADDR_WIDTH   = 12,
    parameter int STRIDE_WIDTH = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH-1:0]   bound_addr_i,
    input  logic [STRIDE_WIDTH-1:0] stride_i,
    input  logic                    wrap_i,
    output logic [ADDR_WIDTH-1:0]   addr_out_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
    output logic [ADDR_WIDTH:0]     xfer_count_o,
`endif
    output logic                    error_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   bound_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic                    wrap_q;

    // One extra bit so a step past the top of the address space is seen
    // as "past the end" instead of silently wrapping to a low address.
    logic [ADDR_WIDTH:0]     next_addr_d;
    logic                    past_end_d;
    logic                    xfer_d;
    logic                    start_ok_d;

    // Next-address arithmetic and handshake decode.
    assign next_addr_d = {1'b0, addr_q} + (ADDR_WIDTH+1)'(stride_q);
    assign past_end_d  = next_addr_d > {1'b0, bound_q};
    assign xfer_d      = valid_q & addr_ready_i;
    assign start_ok_d  = start_i & (base_addr_i <= bound_addr_i);

    // Walk controller: state, address, handshake and status pulses.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            base_q   <= '0;
            bound_q  <= '0;
            stride_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (stop_i) begin
                // Abort wins over everything, including a same-cycle start
                // or transfer; no done pulse is produced.
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok_d) begin
                            base_q   <= base_addr_i;
                            bound_q  <= bound_addr_i;
                            // Stride 0 would never advance; store it as 1.
                            stride_q <= (stride_i == '0) ? STRIDE_WIDTH'(1) : stride_i;
                            wrap_q   <= wrap_i;
                            addr_q   <= base_addr_i;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ST_RUN;
                        end else if (start_i) begin
                            error_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (xfer_d) begin
                            if (!past_end_d) begin
                                addr_q <= next_addr_d[ADDR_WIDTH-1:0];
                            end else if (wrap_q) begin
                                addr_q <= base_q;
                            end else begin
                                // addr_q keeps the last emitted address.
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
    logic [ADDR_WIDTH:0] count_q;

    // Transfer counter: cleared on an accepted start, saturates at all-ones.
    // A transfer coincident with stop was still taken downstream, so it counts.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (!stop_i && (state_q == ST_IDLE) && start_ok_d) begin
            count_q <= '0;
        end else if (xfer_d && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign xfer_count_o = count_q;
`endif

    assign addr_out_o   = addr_q;
    assign addr_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_address_range_generator.sv
// ============================================================================
// Module   : tb_address_range_generator
// Brief    : Self-checking bench for address_range_generator. Expected
//            address sequences are built from the range rules with plain
//            integer arithmetic and compared against the DUT handshake.
// Options  : honours ADDRESS_RANGE_GENERATOR_COUNT_EN for xfer_count_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_address_range_generator;

    localparam int AW = 12;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] bound_addr = '0;
    logic [SW-1:0] stride = '0;
    logic          wrap = 1'b0;
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic          addr_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
    logic [AW:0]   xfer_count;
`endif

    int tests = 0;
    int fails = 0;

    address_range_generator #(.ADDR_WIDTH(AW), .STRIDE_WIDTH(SW)) dut (
        .clock_i      (clock),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .stop_i       (stop),
        .base_addr_i  (base_addr),
        .bound_addr_i (bound_addr),
        .stride_i     (stride),
        .wrap_i       (wrap),
        .addr_out_o   (addr_out),
        .addr_valid_o (addr_valid),
        .addr_ready_i (addr_ready),
        .busy_o       (busy),
        .done_o       (done),
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
        .xfer_count_o (xfer_count),
`endif
        .error_o      (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a walk and follow it to completion (or to stop in wrap mode).
    // rmode: 0 = ready always high, 1 = ready toggles 1,0,1,0..., 2 = random.
    task automatic run_walk(input int b, input int bo, input int s, input bit w,
                            input int rmode, input int nwrap);
        int q[$];
        int se, idx, xf, last;
        bit rdy, fin;
        se = (s == 0) ? 1 : s;
        for (int a = b; a <= bo; a += se) q.push_back(a);

        base_addr  = b[AW-1:0];
        bound_addr = bo[AW-1:0];
        stride     = s[SW-1:0];
        wrap       = w;
        start      = 1'b1;
        addr_ready = 1'b0;
        stop       = 1'b0;
        @(negedge clock);
        start      = 1'b0;
        base_addr  = AW'($urandom);
        bound_addr = AW'($urandom);
        stride     = SW'($urandom);
        wrap       = 1'($urandom);

        idx = 0; xf = 0; last = 0; fin = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            chk("run_valid", 32'(addr_valid), 32'd1);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_error", 32'(error), 32'd0);
            chk("run_addr", 32'(addr_out), q[idx]);
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
            chk("run_count", 32'(xfer_count), xf);
`endif
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom);
            endcase
            addr_ready = rdy;
            start      = 1'($urandom);
            if (rdy) begin
                last = q[idx];
                idx++;
                xf++;
            end
            if (w && rdy && xf == nwrap) stop = 1'b1;
            @(negedge clock);
            start      = 1'b0;
            addr_ready = 1'b0;
            if (stop) begin
                stop = 1'b0;
                chk("stop_valid", 32'(addr_valid), 32'd0);
                chk("stop_busy", 32'(busy), 32'd0);
                chk("stop_done", 32'(done), 32'd0);
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
                chk("stop_count", 32'(xfer_count), xf);
`endif
                fin = 1;
            end else if (!w && idx == q.size()) begin
                chk("end_done", 32'(done), 32'd1);
                chk("end_valid", 32'(addr_valid), 32'd0);
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_addr", 32'(addr_out), last);
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
                chk("end_count", 32'(xfer_count), xf);
`endif
                // A start in the DONE cycle must be ignored.
                start      = 1'b1;
                base_addr  = '0;
                bound_addr = '1;
                @(negedge clock);
                start = 1'b0;
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_valid", 32'(addr_valid), 32'd0);
                chk("idle_addr", 32'(addr_out), last);
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
                chk("idle_count", 32'(xfer_count), xf);
`endif
                fin = 1;
            end else if (idx == q.size()) begin
                idx = 0;
            end
        end
        if (!fin) chk("walk_timeout", 32'd0, 32'd1);
    endtask

    // Rejected start: one-cycle error pulse, no walk begins.
    task automatic check_error(input int b, input int bo);
        base_addr  = b[AW-1:0];
        bound_addr = bo[AW-1:0];
        stride     = SW'($urandom);
        wrap       = 1'($urandom);
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("err_pulse", 32'(error), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_valid", 32'(addr_valid), 32'd0);
        @(negedge clock);
        chk("err_clear", 32'(error), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        int b, bo, s;
        bit w;

        // Reset values.
        #1;
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
        chk("rst_count", 32'(xfer_count), 32'd0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed scenarios.
        run_walk(32'h010, 32'h014, 1, 1'b0, 0, 0);
        run_walk(32'h100, 32'h10A, 4, 1'b0, 1, 0);
        run_walk(32'hFFC, 32'hFFF, 3, 1'b0, 0, 0);
        check_error(32'h020, 32'h01F);
        run_walk(32'h008, 32'h009, 0, 1'b1, 0, 6);
        run_walk(32'h7F0, 32'h7F0, 5, 1'b0, 0, 0);
        run_walk(32'h7F0, 32'h7F0, 5, 1'b1, 2, 4);

        // stop together with start in IDLE: nothing starts, no error.
        base_addr = 12'h001; bound_addr = 12'h002; start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        chk("stopstart_busy", 32'(busy), 32'd0);
        chk("stopstart_valid", 32'(addr_valid), 32'd0);
        chk("stopstart_error", 32'(error), 32'd0);

        // Asynchronous reset in the middle of a walk at 0x012.
        base_addr = 12'h010; bound_addr = 12'h01F; stride = 4'd1; wrap = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        addr_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("pre_reset_addr", 32'(addr_out), 32'h012);
        #2 reset_n = 1'b0;
        #1;
        chk("async_addr", 32'(addr_out), 32'd0);
        chk("async_valid", 32'(addr_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_error", 32'(error), 32'd0);
`ifdef ADDRESS_RANGE_GENERATOR_COUNT_EN
        chk("async_count", 32'(xfer_count), 32'd0);
`endif
        addr_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_walk(32'h040, 32'h047, 2, 1'b0, 2, 0);

        // Randomized walks, including ranges at the top of the address space.
        for (int it = 0; it < 30; it++) begin
            if (it % 6 == 5) begin
                b  = int'($urandom_range(1, 4095));
                bo = int'($urandom_range(0, b - 1));
                check_error(b, bo);
            end else begin
                if (it % 6 == 4) begin
                    b  = int'($urandom_range(4070, 4095));
                    bo = 4095;
                end else begin
                    b  = int'($urandom_range(0, 4095));
                    bo = b + int'($urandom_range(0, 40));
                    if (bo > 4095) bo = 4095;
                end
                s = int'($urandom_range(0, 15));
                w = ($urandom_range(0, 3) == 0);
                run_walk(b, bo, s, w, 2, int'($urandom_range(1, 12)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
